// File: rtl/ws2812_decoder.sv
// WS2812 NRZ stream decoder: classifies high-pulse widths into bits, assembles
// MSB-first 24-bit words and latches the selected word when the low gap ends a frame.
module ws2812_decoder #(
  parameter int unsigned MIN_PULSE    = 2,
  parameter int unsigned BIT_THRESH   = 6,
  parameter int unsigned RESET_CYCLES = 500,
  parameter int unsigned CNT_W        = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  input  logic [7:0]  led_sel,
  output logic [23:0] rgb_out,
  output logic        valid,
  output logic [7:0]  word_count,
  output logic        frame_error,
  output logic        busy
);

  typedef enum logic [2:0] {SYNC, IDLE, HIGH, LOW, LATCH, STUCK} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] THR_CNT  = CNT_W'(BIT_THRESH);

  state_t      state_q;
  logic        sync1_q, din_s_q;
  logic [CNT_W-1:0] hcnt_q, lcnt_q;
  logic [7:0]  sel_q, word_idx_q, word_count_q;
  logic [4:0]  bit_idx_q;
  logic [22:0] shift_q;
  logic [23:0] cap_q, rgb_q;
  logic        hit_q, valid_q, frame_error_q, busy_q;

  logic        bit_d;
  logic [23:0] shift_d;

  always_comb begin
    bit_d   = (hcnt_q >= THR_CNT);
    shift_d = {shift_q, bit_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SYNC;
      sync1_q       <= 1'b0;
      din_s_q       <= 1'b0;
      hcnt_q        <= '0;
      lcnt_q        <= '0;
      sel_q         <= '0;
      word_idx_q    <= '0;
      word_count_q  <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      cap_q         <= '0;
      rgb_q         <= '0;
      hit_q         <= 1'b0;
      valid_q       <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      sync1_q <= din;
      din_s_q <= sync1_q;
      valid_q <= 1'b0;
      case (state_q)
        SYNC: begin
          if (din_s_q)               lcnt_q  <= '0;
          else if (lcnt_q == LAST_CNT) state_q <= IDLE;
          else                        lcnt_q  <= lcnt_q + 1'b1;
        end
        IDLE: begin
          if (din_s_q) begin
            state_q    <= HIGH;
            hcnt_q     <= CNT_W'(1);
            sel_q      <= led_sel;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            word_idx_q <= '0;
            hit_q      <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        HIGH: begin
          if (!din_s_q) begin
            state_q <= LOW;
            lcnt_q  <= CNT_W'(1);
            // Pulses shorter than MIN_PULSE leave the word state untouched.
            if (hcnt_q >= MIN_CNT) begin
              shift_q <= shift_d[22:0];
              if (bit_idx_q == 5'd23) begin
                if (word_idx_q == sel_q) begin
                  cap_q <= shift_d;
                  hit_q <= 1'b1;
                end
                if (word_idx_q != 8'hFF) word_idx_q <= word_idx_q + 1'b1;
                bit_idx_q <= '0;
              end else begin
                bit_idx_q <= bit_idx_q + 1'b1;
              end
            end
          end else if (hcnt_q == LAST_CNT) begin
            state_q       <= STUCK;
            frame_error_q <= 1'b1;
            busy_q        <= 1'b0;
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
        LOW: begin
          if (din_s_q) begin
            state_q <= HIGH;
            hcnt_q  <= CNT_W'(1);
          end else if (lcnt_q == LAST_CNT) begin
            state_q <= LATCH;
          end else begin
            lcnt_q <= lcnt_q + 1'b1;
          end
        end
        LATCH: begin
          word_count_q  <= word_idx_q;
          frame_error_q <= (bit_idx_q != '0);
          if (hit_q) begin
            rgb_q   <= cap_q;
            valid_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        STUCK: begin
          // The first low sample already counts toward the resync gap.
          if (!din_s_q) begin
            state_q <= SYNC;
            lcnt_q  <= CNT_W'(1);
          end
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign rgb_out     = rgb_q;
  assign valid       = valid_q;
  assign word_count  = word_count_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ws2812_decoder.sv
// Directed bench for ws2812_decoder: table of whole frames plus hand sequences
// for threshold, partial word, stuck-high, latency and mid-frame reset.
module tb_ws2812_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din = 1'b0;
  logic [7:0]  led_sel = '0;
  logic [23:0] rgb_out;
  logic        valid;
  logic [7:0]  word_count;
  logic        frame_error;
  logic        busy;

  int total = 0;
  int bad = 0;
  int vcnt = 0;

  ws2812_decoder #(
    .MIN_PULSE(2), .BIT_THRESH(6), .RESET_CYCLES(500), .CNT_W(10)
  ) dut (
    .clk(clk), .reset(reset), .din(din), .led_sel(led_sel),
    .rgb_out(rgb_out), .valid(valid), .word_count(word_count),
    .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid === 1'b1) vcnt++;

  typedef struct {
    logic [7:0]        sel;
    int                nw;
    logic [2:0][23:0]  words;
    int                exp_valid;
    logic [23:0]       exp_rgb;
    logic [7:0]        exp_wc;
    logic              exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every call starts and ends on a falling clock edge.
  task automatic hold(input logic lvl, input int n);
    din = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) begin hold(1'b1, 8); hold(1'b0, 4); end
    else   begin hold(1'b1, 4); hold(1'b0, 8); end
  endtask

  task automatic send_bits(input logic [23:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(w[i]);
  endtask

  vec_t vecs [4];
  int   v0, n;

  initial begin
    vecs[0] = '{8'd0, 1, {24'h0, 24'h0, 24'hA53C0F}, 1, 24'hA53C0F, 8'd1, 1'b0};
    vecs[1] = '{8'd2, 3, {24'hABCDEF, 24'h222222, 24'h111111}, 1, 24'hABCDEF, 8'd3, 1'b0};
    vecs[2] = '{8'd5, 2, {24'h0, 24'h654321, 24'h123456}, 0, 24'hABCDEF, 8'd2, 1'b0};
    vecs[3] = '{8'd1, 2, {24'h0, 24'hFFFFFF, 24'h000000}, 1, 24'hFFFFFF, 8'd2, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_rgb", 32'(rgb_out), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_wc", 32'(word_count), 0);
    chk("rst_err", 32'(frame_error), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    hold(1'b0, 600);

    for (int k = 0; k < 4; k++) begin
      led_sel = vecs[k].sel;
      v0 = vcnt;
      for (int w = 0; w < vecs[k].nw; w++) send_bits(vecs[k].words[w], 23, 0);
      hold(1'b0, 600);
      chk($sformatf("tab%0d_valid", k), 32'(vcnt - v0), 32'(vecs[k].exp_valid));
      chk($sformatf("tab%0d_rgb", k), 32'(rgb_out), 32'(vecs[k].exp_rgb));
      chk($sformatf("tab%0d_wc", k), 32'(word_count), 32'(vecs[k].exp_wc));
      chk($sformatf("tab%0d_err", k), 32'(frame_error), 32'(vecs[k].exp_err));
      chk($sformatf("tab%0d_busy", k), 32'(busy), 0);
    end

    // Pulse-width boundaries: 1 ignored, 2 -> 0, 5 -> 0, 6 -> 1
    led_sel = 8'd0;
    v0 = vcnt;
    send_bits(24'h1ABCDE, 20, 0);
    hold(1'b1, 1); hold(1'b0, 8);
    hold(1'b1, 2); hold(1'b0, 8);
    hold(1'b1, 5); hold(1'b0, 8);
    hold(1'b1, 6); hold(1'b0, 8);
    hold(1'b0, 600);
    chk("thr_valid", 32'(vcnt - v0), 1);
    chk("thr_rgb", 32'(rgb_out), 32'h00D5E6F1);
    chk("thr_wc", 32'(word_count), 1);

    // 30 bits: one full word plus a partial one
    v0 = vcnt;
    send_bits(24'h5A5A5A, 23, 0);
    send_bits(24'h00002A, 5, 0);
    hold(1'b0, 600);
    chk("part_valid", 32'(vcnt - v0), 1);
    chk("part_rgb", 32'(rgb_out), 32'h005A5A5A);
    chk("part_wc", 32'(word_count), 1);
    chk("part_err", 32'(frame_error), 1);

    // Glitch-only frame still latches with zero words
    v0 = vcnt;
    hold(1'b1, 1);
    hold(1'b0, 600);
    chk("glitch_valid", 32'(vcnt - v0), 0);
    chk("glitch_wc", 32'(word_count), 0);
    chk("glitch_err", 32'(frame_error), 0);

    // Stuck high
    v0 = vcnt;
    hold(1'b1, 490);
    chk("stuck_early_err", 32'(frame_error), 0);
    hold(1'b1, 110);
    chk("stuck_err", 32'(frame_error), 1);
    chk("stuck_busy", 32'(busy), 0);
    chk("stuck_valid", 32'(vcnt - v0), 0);
    hold(1'b0, 500);
    send_bits(24'h0F1E2D, 23, 0);
    hold(1'b0, 600);
    chk("recov_valid", 32'(vcnt - v0), 1);
    chk("recov_rgb", 32'(rgb_out), 32'h000F1E2D);
    chk("recov_err", 32'(frame_error), 0);
    chk("recov_wc", 32'(word_count), 1);

    // Latency from the last din fall to valid (2 sync + 500 gap + latch)
    send_bits(24'h800001, 23, 1);
    hold(1'b1, 8);
    din = 1'b0;
    n = 0;
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      if (valid === 1'b1) begin n = c; break; end
    end
    chk("lat_cycles", 32'(n), 503);
    hold(1'b0, 50);
    chk("lat_rgb", 32'(rgb_out), 32'h00800001);

    // Reset in the middle of a word
    send_bits(24'hFFF000, 23, 12);
    reset = 1'b1;
    #1;
    chk("mid_rst_rgb", 32'(rgb_out), 0);
    chk("mid_rst_wc", 32'(word_count), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    v0 = vcnt;
    send_bits(24'hFFF000, 11, 0);
    send_bits(24'h123456, 23, 0);
    hold(1'b0, 600);
    chk("resume_valid", 32'(vcnt - v0), 0);
    chk("resume_rgb", 32'(rgb_out), 0);
    chk("resume_wc", 32'(word_count), 0);
    send_bits(24'h3C5AA5, 23, 0);
    hold(1'b0, 600);
    chk("post_valid", 32'(vcnt - v0), 1);
    chk("post_rgb", 32'(rgb_out), 32'h003C5AA5);
    chk("post_wc", 32'(word_count), 1);
    chk("post_err", 32'(frame_error), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws2812_decoder.md
Name: ws2812_decoder

Overview:
- Receive-side counterpart of the ws2812 LED-chain driver: decodes the single-wire WS2812 NRZ pulse stream the way an LED chip does.
- Classifies each high pulse by width as a 0 or 1 bit and assembles MSB-first 24-bit words.
- Captures the word at a selectable chain position and presents it when the >50 us low latch gap ends the frame.
- Used as an on-chip loopback checker and as an input project for the multi-project harness.

Parameters:
- MIN_PULSE, 2: high pulses shorter than this many cycles are glitches and are ignored.
- BIT_THRESH, 6: a high pulse of at least this many cycles decodes as 1, otherwise 0 (0.6 us at 10 MHz).
- RESET_CYCLES, 500: low time, in cycles, that latches a frame (50 us at 10 MHz); also the high time that flags stuck-high.
- CNT_W, 10: width of the pulse counters; must satisfy 2^CNT_W > RESET_CYCLES.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- din  input  1  WS2812 serial data line, asynchronous to clk
- led_sel  input  8  chain position (word index) to capture; sampled at the first rising edge of each frame
- rgb_out  output  24  captured word, in on-wire order
- valid  output  1  one-cycle pulse when rgb_out is updated
- word_count  output  8  number of complete words in the last frame; saturates at 255
- frame_error  output  1  last frame was malformed (partial word or stuck-high)
- busy  output  1  high while a frame is in progress

Behaviour:
- Synchronisation: din passes through a 2-FF synchroniser to give din_s. All counts and latencies below are measured on din_s.
- Reset values: all outputs are 0, and the FSM enters SYNC. Reset may assert mid-frame; the partial frame is discarded and no valid pulse is produced.
- FSM states:
  - SYNC: requires din_s low for RESET_CYCLES consecutive cycles, then goes to IDLE. A high sample restarts the count. This prevents decoding from the middle of a frame.
  - IDLE: on a din_s rising edge, go to HIGH with hcnt=1, sample led_sel, and clear the shift register, bit_idx, word_idx and hit. busy=1.
  - HIGH: hcnt increments once per cycle.
    - On a falling edge with hcnt<MIN_PULSE: glitch; go to LOW without shifting.
    - Otherwise shift in bit = (hcnt>=BIT_THRESH) and go to LOW with lcnt=1.
    - If hcnt reaches RESET_CYCLES: set frame_error=1 immediately, discard the frame, go to STUCK.
  - LOW: lcnt increments. A rising edge goes to HIGH with hcnt=1. When lcnt reaches RESET_CYCLES, go to LATCH.
  - LATCH (single cycle), then IDLE with busy=0:
    - word_count <= word_idx.
    - frame_error <= (bit_idx != 0).
    - If hit: rgb_out <= capture register and valid=1.
  - STUCK: wait for din_s low, then go to SYNC.
- Word assembly:
  - bit_idx counts 0..23.
  - On the 24th bit: if word_idx==led_sel, copy the shift register plus the new bit into the capture register and set hit. Then word_idx increments, saturating at 255, and bit_idx returns to 0.
- Latency: valid is asserted exactly RESET_CYCLES cycles after the last synchronised falling edge, plus 1 cycle for LATCH.
- rgb_out and word_count hold their values between latches. valid never asserts for a frame without a hit or for a stuck-high frame.
- A frame with zero decoded bits (only glitches) still latches: word_count=0, frame_error=0, no valid.

Test Plan:
Defaults at 10 MHz. Bit 0 = 4 cycles high + 8 low; bit 1 = 8 high + 4 low.
- Reset, 600 low cycles, led_sel=0, one word 0xA53C0F, 600 low -> exactly one valid pulse; rgb_out=0xA53C0F, word_count=1, frame_error=0, busy low after the latch.
- led_sel=2, words 0x111111, 0x222222, 0xABCDEF -> rgb_out=0xABCDEF, word_count=3. Then led_sel=5 with a 2-word frame -> no valid, rgb_out stays 0xABCDEF, word_count=2.
- Threshold boundary: high pulses of 1, 2, 5 and 6 cycles -> the first is ignored; the others decode as 0, 0, 1. Verify by packing them into a word with known padding bits.
- 30 valid bits, then gap -> word_count=1, frame_error=1, valid only if led_sel=0.
- din held high for 600 cycles -> frame_error=1 at high-cycle 500, no valid. Then 500 low cycles plus a clean frame -> frame_error=0 and correct capture.
- Assert reset at bit 12 of a word -> all outputs 0 immediately. Bits resumed without a 500-cycle low gap are not decoded. After the gap a full frame decodes correctly.
